// File: rtl/ysyx_24080006_mem_arb.sv
// ysyx_24080006_mem_arb: round-robin IFU/LSU arbiter onto one bus with address legality check and response timeout; define NPC_SRAM_EN to map 0x8000_0000-0x87ff_ffff
module ysyx_24080006_mem_arb #(
  parameter int TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_req_addr,
  output logic        ifu_resp_valid,
  output logic [31:0] ifu_resp_data,
  output logic        ifu_resp_err,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [31:0] lsu_req_addr,
  input  logic        lsu_req_we,
  input  logic [31:0] lsu_req_wdata,
  input  logic [3:0]  lsu_req_wstrb,
  output logic        lsu_resp_valid,
  output logic [31:0] lsu_resp_data,
  output logic        lsu_resp_err,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic [31:0] bus_req_addr,
  output logic        bus_req_we,
  output logic [31:0] bus_req_wdata,
  output logic [3:0]  bus_req_wstrb,
  input  logic        bus_resp_valid,
  input  logic [31:0] bus_resp_data,
  input  logic        bus_resp_err
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state_q;
  logic last_lsu_q, sel_lsu_q, we_q, err_q, ifu_rv_q, lsu_rv_q;
  logic [31:0] addr_q, wdata_q, data_q;
  logic [3:0] wstrb_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic gnt, legal, psram, sram, flash, sdram, clint, uart, gpio, ps2, vga;
  logic [31:0] a;

  function automatic logic in_rng(input logic [31:0] x, input logic [31:0] lo, input logic [31:0] hi);
    return x >= lo && x <= hi;
  endfunction

  assign ifu_req_ready = reset_n && state_q == IDLE && ifu_req_valid && !(lsu_req_valid && !last_lsu_q);
  assign lsu_req_ready = reset_n && state_q == IDLE && lsu_req_valid && !(ifu_req_valid && last_lsu_q);
  assign gnt = ifu_req_ready | lsu_req_ready;
  assign a = lsu_req_ready ? lsu_req_addr : ifu_req_addr;

  assign sram  = in_rng(a, 32'h0f00_0000, 32'h0f00_1fff);
  assign flash = in_rng(a, 32'h3000_0000, 32'h30ff_ffff);
  assign sdram = in_rng(a, 32'ha000_0000, 32'ha3ff_ffff);
  assign clint = in_rng(a, 32'h0200_0000, 32'h0200_ffff);
  assign uart  = in_rng(a, 32'h1000_0000, 32'h1000_0fff);
  assign gpio  = in_rng(a, 32'h1000_2000, 32'h1000_200f);
  assign ps2   = in_rng(a, 32'h1001_1000, 32'h1001_1007);
  assign vga   = in_rng(a, 32'h2100_0000, 32'h211f_ffff);
`ifdef NPC_SRAM_EN
  assign psram = in_rng(a, 32'h8000_0000, 32'h87ff_ffff);
`else
  assign psram = 1'b0;
`endif

  assign legal = !lsu_req_ready ? (sram | flash | sdram | psram) :
                 lsu_req_we     ? (sram | sdram | uart | gpio | vga | psram) :
                                  (sram | flash | sdram | psram | clint | uart | gpio | ps2 | vga);
  assign cnt_d = cnt_q + 1'b1;

  assign bus_req_valid  = state_q == ISSUE;
  assign bus_req_addr   = addr_q;
  assign bus_req_we     = we_q;
  assign bus_req_wdata  = wdata_q;
  assign bus_req_wstrb  = wstrb_q;
  assign ifu_resp_valid = ifu_rv_q;
  assign lsu_resp_valid = lsu_rv_q;
  assign ifu_resp_data  = ifu_rv_q ? data_q : 32'h0;
  assign lsu_resp_data  = lsu_rv_q ? data_q : 32'h0;
  assign ifu_resp_err   = ifu_rv_q & err_q;
  assign lsu_resp_err   = lsu_rv_q & err_q;

  // Transaction FSM: grant/latch, issue, wait with timeout, one-cycle response pulse
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      last_lsu_q <= 1'b0;
      sel_lsu_q  <= 1'b0;
      addr_q     <= 32'h0;
      we_q       <= 1'b0;
      wdata_q    <= 32'h0;
      wstrb_q    <= 4'h0;
      data_q     <= 32'h0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      ifu_rv_q   <= 1'b0;
      lsu_rv_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (gnt) begin
          sel_lsu_q  <= lsu_req_ready;
          last_lsu_q <= lsu_req_ready;
          addr_q     <= a;
          we_q       <= lsu_req_ready & lsu_req_we;
          wdata_q    <= lsu_req_ready ? lsu_req_wdata : 32'h0;
          wstrb_q    <= lsu_req_ready ? lsu_req_wstrb : 4'h0;
          if (legal) state_q <= ISSUE;
          else begin
            state_q  <= RESP;
            data_q   <= 32'h0;
            err_q    <= 1'b1;
            ifu_rv_q <= ~lsu_req_ready;
            lsu_rv_q <= lsu_req_ready;
          end
        end
        ISSUE: if (bus_req_ready) begin
          state_q <= WAIT;
          cnt_q   <= '0;
        end
        WAIT: if (bus_resp_valid || cnt_d == CW'(TIMEOUT)) begin
          state_q  <= RESP;
          data_q   <= bus_resp_valid ? bus_resp_data : 32'h0;
          err_q    <= bus_resp_valid ? bus_resp_err : 1'b1;
          ifu_rv_q <= ~sel_lsu_q;
          lsu_rv_q <= sel_lsu_q;
        end else cnt_q <= cnt_d;
        RESP: begin
          state_q  <= IDLE;
          ifu_rv_q <= 1'b0;
          lsu_rv_q <= 1'b0;
          err_q    <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
